// File: rtl/mem_block_arbiter.sv
// mem_block_arbiter
// Fixed-latency sequencer that shares one block-wide memory port between the
// instruction-cache refill path (read only) and the data-cache path (read or
// write). Arbitration is round-robin on ties and happens only while idle.
// Each transfer holds its strobe for a fixed number of cycles. Completion is
// reported with a one-cycle done pulse in the first idle cycle afterwards.

module mem_block_arbiter #(
   parameter int WORD_SIZE     = 16,
   parameter int BLOCK_SIZE    = 64,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   // instruction-cache refill port
   input  logic                  i_req,
   input  logic [WORD_SIZE-1:0]  i_address,
   output logic                  i_done,
   output logic [BLOCK_SIZE-1:0] i_rdata,
   // data-cache refill / writeback port
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [WORD_SIZE-1:0]  d_address,
   input  logic [BLOCK_SIZE-1:0] d_wdata,
   output logic                  d_done,
   output logic [BLOCK_SIZE-1:0] d_rdata,
   // unified block memory port
   output logic                  m_readM,
   output logic                  m_writeM,
   output logic [WORD_SIZE-1:0]  m_address,
   output logic [BLOCK_SIZE-1:0] m_wdata,
   input  logic [BLOCK_SIZE-1:0] m_rdata,
   // status
   output logic                  busy
);

   // The counter only ever holds latency-1, so clog2 of the larger latency
   // is enough. Keep at least one bit so both latencies can be 1.
   localparam int MAX_LATENCY = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W       = (MAX_LATENCY > 1) ? $clog2(MAX_LATENCY) : 1;

   localparam logic [CNT_W-1:0]     READ_LOAD  = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0]     WRITE_LOAD = CNT_W'(WRITE_LATENCY - 1);
   // Clears the word-within-block bits, which gives the block-aligned address.
   localparam logic [WORD_SIZE-1:0] ALIGN_MASK = {{(WORD_SIZE-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      I_READ  = 2'd1,
      D_READ  = 2'd2,
      D_WRITE = 2'd3
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [CNT_W-1:0]      count;
   logic                  last_grant_d;   // 0: I was granted last, 1: D was
   logic [WORD_SIZE-1:0]  addr_q;
   logic [BLOCK_SIZE-1:0] wdata_q;

   logic                  i_pending;
   logic                  d_pending;
   logic                  grant_i;
   logic                  grant_d;
   logic                  xfer_last;

   // A requester whose done is high this cycle is still dropping its req.
   // Ignore it so the finished transfer is not granted a second time.
   assign i_pending = i_req & ~i_done;
   assign d_pending = d_req & ~d_done;

   // State register
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the values from before the edge, whatever the order of
   // the always_ff blocks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Arbitration, next-state logic and memory-port drive
   always_comb begin
      // NOTE: every output of this block is given a default first. No path can
      // then leave a signal unassigned, so no latch is inferred.
      next_state = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      xfer_last  = 1'b0;
      busy       = 1'b0;
      m_readM    = 1'b0;
      m_writeM   = 1'b0;
      m_address  = '0;
      m_wdata    = '0;

      case (state)
         IDLE: begin
            // D wins a tie unless D was the last one served.
            if (d_pending && (!i_pending || !last_grant_d)) begin
               grant_d    = 1'b1;
               next_state = d_we ? D_WRITE : D_READ;
            end else if (i_pending) begin
               grant_i    = 1'b1;
               next_state = I_READ;
            end
         end

         I_READ, D_READ: begin
            busy      = 1'b1;
            m_readM   = 1'b1;
            m_address = addr_q;
            xfer_last = (count == '0);
            if (xfer_last) begin
               next_state = IDLE;
            end
         end

         D_WRITE: begin
            busy      = 1'b1;
            m_writeM  = 1'b1;
            m_address = addr_q;
            m_wdata   = wdata_q;
            xfer_last = (count == '0);
            if (xfer_last) begin
               next_state = IDLE;
            end
         end

         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Grant-time capture: aligned address, write block, countdown, last grant
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         last_grant_d <= 1'b0;
      end else if (grant_i) begin
         addr_q       <= i_address & ALIGN_MASK;
         count        <= READ_LOAD;
         last_grant_d <= 1'b0;
      end else if (grant_d) begin
         addr_q       <= d_address & ALIGN_MASK;
         count        <= d_we ? WRITE_LOAD : READ_LOAD;
         last_grant_d <= 1'b1;
         if (d_we) begin
            wdata_q <= d_wdata;
         end
      end else if (busy && !xfer_last) begin
         // Stops at zero; a zero count always ends the transfer.
         count <= count - 1'b1;
      end
   end

   // Completion: one-cycle done pulses and read-data capture on the final beat
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i_done  <= 1'b0;
         d_done  <= 1'b0;
         i_rdata <= '0;
         d_rdata <= '0;
      end else begin
         i_done <= xfer_last && (state == I_READ);
         d_done <= xfer_last && ((state == D_READ) || (state == D_WRITE));
         if (xfer_last && (state == I_READ)) begin
            i_rdata <= m_rdata;
         end
         if (xfer_last && (state == D_READ)) begin
            d_rdata <= m_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Testbench for mem_block_arbiter: directed scenarios on a default-latency
// instance, a latency sweep on a second instance (READ=1, WRITE=3), and a
// randomized run checked against a transaction-level model of the arbiter.

module tb_mem_block_arbiter;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // default instance (READ_LATENCY=4, WRITE_LATENCY=1)
   logic        i_req, i_done, d_req, d_we, d_done, m_readM, m_writeM, busy;
   logic [15:0] i_address, d_address, m_address;
   logic [63:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;

   // sweep instance (READ_LATENCY=1, WRITE_LATENCY=3)
   logic        p_i_req, p_i_done, p_d_req, p_d_we, p_d_done, p_m_readM, p_m_writeM, p_busy;
   logic [15:0] p_i_address, p_d_address, p_m_address;
   logic [63:0] p_i_rdata, p_d_rdata, p_d_wdata, p_m_wdata, p_m_rdata;

   logic [63:0] data_key = 64'h0;
   int          rd_cnt, p_rd_cnt;
   int          n_pass = 0;
   int          n_total = 0;

   // Memory contents as a fixed function of the aligned address.
   function automatic logic [63:0] mem_word(input logic [15:0] a, input logic [63:0] key);
      return {a, a, a, a} ^ key;
   endfunction

   // The memory returns valid data only in the last cycle of a read strobe.
   // Sampling in any other cycle gives the inverted, wrong block.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_cnt   <= 0;
         p_rd_cnt <= 0;
      end else begin
         rd_cnt   <= m_readM ? rd_cnt + 1 : 0;
         p_rd_cnt <= p_m_readM ? p_rd_cnt + 1 : 0;
      end
   end

   assign m_rdata   = (m_readM && rd_cnt == 3) ? mem_word(m_address, data_key)
                                               : ~mem_word(m_address, data_key);
   assign p_m_rdata = (p_m_readM && p_rd_cnt == 0) ? mem_word(p_m_address, data_key)
                                                   : ~mem_word(p_m_address, data_key);

   mem_block_arbiter #(.WORD_SIZE(16), .BLOCK_SIZE(64), .READ_LATENCY(4), .WRITE_LATENCY(1)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_address(i_address), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_address(d_address), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
   );

   mem_block_arbiter #(.WORD_SIZE(16), .BLOCK_SIZE(64), .READ_LATENCY(1), .WRITE_LATENCY(3)) u_sweep (
      .clk(clk), .reset_n(reset_n),
      .i_req(p_i_req), .i_address(p_i_address), .i_done(p_i_done), .i_rdata(p_i_rdata),
      .d_req(p_d_req), .d_we(p_d_we), .d_address(p_d_address), .d_wdata(p_d_wdata),
      .d_done(p_d_done), .d_rdata(p_d_rdata),
      .m_readM(p_m_readM), .m_writeM(p_m_writeM), .m_address(p_m_address),
      .m_wdata(p_m_wdata), .m_rdata(p_m_rdata), .busy(p_busy)
   );

   // {readM, writeM, busy, i_done, d_done, address}
   function automatic logic [20:0] pack(input logic rd, input logic wr, input logic bsy,
                                        input logic idn, input logic ddn, input logic [15:0] a);
      return {rd, wr, bsy, idn, ddn, a};
   endfunction

   function automatic logic [20:0] obs();
      return {m_readM, m_writeM, busy, i_done, d_done, m_address};
   endfunction

   function automatic logic [20:0] p_obs();
      return {p_m_readM, p_m_writeM, p_busy, p_i_done, p_d_done, p_m_address};
   endfunction

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Short asynchronous reset pulse between clock edges.
   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [228:0] got;
      #12;
      got = {i_done, d_done, m_readM, m_writeM, busy, m_address, m_wdata, i_rdata, d_rdata};
      n_total++;
      if (got !== '0) $display("FAIL reset_outputs got=%h required=0", got);
      else n_pass++;
      got = {p_i_done, p_d_done, p_m_readM, p_m_writeM, p_busy, p_m_address, p_m_wdata, p_i_rdata, p_d_rdata};
      n_total++;
      if (got !== '0) $display("FAIL reset_outputs_sweep got=%h required=0", got);
      else n_pass++;
      step();
      reset_n = 1'b1;
      step();
      n_total++;
      if (obs() !== 21'h0) $display("FAIL idle_after_reset got=%h required=0", obs());
      else n_pass++;
   endtask

   task automatic test_single_i_read();
      logic [63:0] blk;
      logic [20:0] exp;
      blk       = 64'h6000_f01c_6100_f41c;
      data_key  = blk ^ {4{16'h0024}};
      i_address = 16'h0025;
      i_req     = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         exp = (k <= 4) ? pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0024)
                        : pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
         n_total++;
         if (obs() !== exp) $display("FAIL i_read cycle=%0d got=%h required=%h", k, obs(), exp);
         else n_pass++;
      end
      n_total++;
      if (i_rdata !== blk) $display("FAIL i_read_data got=%h required=%h", i_rdata, blk);
      else n_pass++;
      i_req = 1'b0;
   endtask

   task automatic test_single_d_write();
      logic [20:0] exp;
      step();
      d_address = 16'h001d;
      d_we      = 1'b1;
      d_wdata   = 64'h1111_2222_3333_4444;
      d_req     = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         exp = (k == 1) ? pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h001c) :
               (k == 2) ? pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000) : 21'h0;
         n_total++;
         if (obs() !== exp) $display("FAIL d_write cycle=%0d got=%h required=%h", k, obs(), exp);
         else n_pass++;
         if (k == 1) begin
            n_total++;
            if (m_wdata !== 64'h1111_2222_3333_4444)
               $display("FAIL d_write_wdata got=%h required=%h", m_wdata, 64'h1111_2222_3333_4444);
            else n_pass++;
         end
         if (k == 2) d_req = 1'b0;
      end
      d_we = 1'b0;
   endtask

   task automatic test_tie_after_reset();
      logic [20:0] exp;
      step();
      do_reset();
      data_key  = {$urandom, $urandom};
      i_address = 16'h0081;
      d_address = 16'h0042;
      d_we      = 1'b0;
      i_req     = 1'b1;
      d_req     = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k <= 4)      exp = pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040);
         else if (k == 5) exp = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
         else if (k <= 9) exp = pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0080);
         else             exp = pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
         n_total++;
         if (obs() !== exp) $display("FAIL tie cycle=%0d got=%h required=%h", k, obs(), exp);
         else n_pass++;
         if (k == 5) begin
            d_req = 1'b0;
            n_total++;
            if (d_rdata !== mem_word(16'h0040, data_key))
               $display("FAIL tie_d_data got=%h required=%h", d_rdata, mem_word(16'h0040, data_key));
            else n_pass++;
         end
         if (k == 10) begin
            i_req = 1'b0;
            n_total++;
            if (i_rdata !== mem_word(16'h0080, data_key))
               $display("FAIL tie_i_data got=%h required=%h", i_rdata, mem_word(16'h0080, data_key));
            else n_pass++;
         end
      end
   endtask

   task automatic test_fairness();
      logic [20:0] exp;
      logic        serve_d;
      int          r;
      step();
      do_reset();
      i_address = 16'h0100;
      d_address = 16'h0200;
      d_we      = 1'b0;
      i_req     = 1'b1;
      d_req     = 1'b1;
      // Both stay requesting, so each 5-cycle window serves the other side.
      for (int k = 1; k <= 20; k++) begin
         step();
         serve_d = (((k - 1) / 5) % 2) == 0;
         r       = (k - 1) % 5;
         if (r < 4) exp = pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, serve_d ? 16'h0200 : 16'h0100);
         else       exp = pack(1'b0, 1'b0, 1'b0, !serve_d, serve_d, 16'h0000);
         n_total++;
         if (obs() !== exp) $display("FAIL fairness cycle=%0d got=%h required=%h", k, obs(), exp);
         else n_pass++;
      end
      i_req = 1'b0;
      d_req = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      logic [20:0] exp;
      step();
      do_reset();
      i_address = 16'h0abc;
      i_req     = 1'b1;
      step();
      step();
      n_total++;
      if (obs() !== pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0abc))
         $display("FAIL mid_read_active got=%h required=%h", obs(), pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0abc));
      else n_pass++;
      reset_n = 1'b0;
      #1;
      n_total++;
      if ({obs(), i_rdata, d_rdata} !== '0)
         $display("FAIL async_reset got=%h required=0", {obs(), i_rdata, d_rdata});
      else n_pass++;
      i_req = 1'b0;
      step();
      reset_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         n_total++;
         if (obs() !== 21'h0) $display("FAIL no_done_after_reset cycle=%0d got=%h required=0", k, obs());
         else n_pass++;
      end
      d_address = 16'h0333;
      d_we      = 1'b0;
      d_req     = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         exp = (k <= 4) ? pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0330)
                        : pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
         n_total++;
         if (obs() !== exp) $display("FAIL read_after_reset cycle=%0d got=%h required=%h", k, obs(), exp);
         else n_pass++;
      end
      n_total++;
      if (d_rdata !== mem_word(16'h0330, data_key))
         $display("FAIL read_after_reset_data got=%h required=%h", d_rdata, mem_word(16'h0330, data_key));
      else n_pass++;
      d_req = 1'b0;
   endtask

   task automatic test_param_sweep();
      logic [20:0] exp;
      step();
      p_i_address = 16'h0777;
      p_i_req     = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         step();
         exp = (k == 1) ? pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0774)
                        : pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
         n_total++;
         if (p_obs() !== exp) $display("FAIL sweep_read cycle=%0d got=%h required=%h", k, p_obs(), exp);
         else n_pass++;
      end
      n_total++;
      if (p_i_rdata !== mem_word(16'h0774, data_key))
         $display("FAIL sweep_read_data got=%h required=%h", p_i_rdata, mem_word(16'h0774, data_key));
      else n_pass++;
      p_i_req = 1'b0;
      step();
      p_d_address = 16'h0999;
      p_d_we      = 1'b1;
      p_d_wdata   = 64'hdead_beef_0123_4567;
      p_d_req     = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         exp = (k <= 3) ? pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0998)
                        : pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
         n_total++;
         if (p_obs() !== exp) $display("FAIL sweep_write cycle=%0d got=%h required=%h", k, p_obs(), exp);
         else n_pass++;
         if (k <= 3) begin
            n_total++;
            if (p_m_wdata !== 64'hdead_beef_0123_4567)
               $display("FAIL sweep_write_wdata cycle=%0d got=%h required=%h", k, p_m_wdata, 64'hdead_beef_0123_4567);
            else n_pass++;
         end
      end
      p_d_req = 1'b0;
      p_d_we  = 1'b0;
   endtask

   // Randomized traffic against a transaction-level model: a single shared
   // port, round-robin on ties, grant decided at the end of any cycle in which
   // no strobe is active, and done one cycle after the last strobe cycle.
   task automatic test_random();
      int          cur_who;    // 0 none, 1 I, 2 D
      int          cur_start, cur_end, done_at;
      logic        cur_we, last_d, pend_i, pend_d, rd, wr, fin_i, fin_d;
      logic [15:0] cur_addr;
      logic [63:0] cur_wdata;
      logic [20:0] exp;
      step();
      do_reset();
      data_key  = {$urandom, $urandom};
      cur_who   = 0;
      cur_start = 0;
      cur_end   = -1;
      done_at   = -1;
      cur_we    = 1'b0;
      cur_addr  = 16'h0;
      cur_wdata = 64'h0;
      last_d    = 1'b0;
      pend_i    = 1'b0;
      pend_d    = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (c > 0) step();
         wr = (cur_who != 0) && (c >= cur_start) && (c <= cur_end) && cur_we;
         rd = (cur_who != 0) && (c >= cur_start) && (c <= cur_end) && !cur_we;
         fin_i = (c == done_at) && (cur_who == 1);
         fin_d = (c == done_at) && (cur_who == 2);
         exp = pack(rd, wr, rd | wr, fin_i, fin_d, (rd | wr) ? cur_addr : 16'h0000);
         n_total++;
         if (obs() !== exp) $display("FAIL random cycle=%0d got=%h required=%h", c, obs(), exp);
         else n_pass++;
         if (wr) begin
            n_total++;
            if (m_wdata !== cur_wdata) $display("FAIL random_wdata cycle=%0d got=%h required=%h", c, m_wdata, cur_wdata);
            else n_pass++;
         end
         if (fin_i) begin
            n_total++;
            if (i_rdata !== mem_word(cur_addr, data_key))
               $display("FAIL random_i_data cycle=%0d got=%h required=%h", c, i_rdata, mem_word(cur_addr, data_key));
            else n_pass++;
            pend_i = 1'b0;
            i_req  = 1'b0;
         end
         if (fin_d) begin
            if (!cur_we) begin
               n_total++;
               if (d_rdata !== mem_word(cur_addr, data_key))
                  $display("FAIL random_d_data cycle=%0d got=%h required=%h", c, d_rdata, mem_word(cur_addr, data_key));
               else n_pass++;
            end
            pend_d = 1'b0;
            d_req  = 1'b0;
         end
         // New requests, never from a requester in its own done cycle.
         if (!pend_i && !fin_i && $urandom_range(0, 3) == 0) begin
            pend_i    = 1'b1;
            i_address = 16'($urandom);
            i_req     = 1'b1;
         end
         if (!pend_d && !fin_d && $urandom_range(0, 3) == 0) begin
            pend_d    = 1'b1;
            d_we      = 1'($urandom_range(0, 1));
            d_address = 16'($urandom);
            d_wdata   = {$urandom, $urandom};
            d_req     = 1'b1;
         end
         // Grant decision at the end of this cycle.
         if ((c > cur_end) && (pend_i || pend_d)) begin
            if (pend_d && (!pend_i || !last_d)) begin
               cur_who   = 2;
               cur_we    = d_we;
               cur_addr  = d_address & 16'hfffc;
               cur_wdata = d_wdata;
               last_d    = 1'b1;
            end else begin
               cur_who  = 1;
               cur_we   = 1'b0;
               cur_addr = i_address & 16'hfffc;
               last_d   = 1'b0;
            end
            cur_start = c + 1;
            cur_end   = c + (cur_we ? 1 : 4);
            done_at   = cur_end + 1;
         end
      end
      i_req = 1'b0;
      d_req = 1'b0;
   endtask

   initial begin
      i_req = 1'b0; i_address = '0; d_req = 1'b0; d_we = 1'b0; d_address = '0; d_wdata = '0;
      p_i_req = 1'b0; p_i_address = '0; p_d_req = 1'b0; p_d_we = 1'b0; p_d_address = '0; p_d_wdata = '0;
      test_reset();
      test_single_i_read();
      test_single_d_write();
      test_tie_after_reset();
      test_fairness();
      test_reset_mid_read();
      test_param_sweep();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_block_arbiter.md
# mem_block_arbiter

Fixed-latency memory sequencer that shares one block-wide memory port between the instruction-cache refill path and the data-cache refill/writeback path. It arbitrates between the two requesters and drives the memory port's read/write strobes and block-aligned address for the configured number of cycles. It captures the returned 64-bit block and signals completion with a one-cycle done pulse. It sits between the I/D cache controllers and the unified block memory.

## Interface
- WORD_SIZE, 16, address width in bits
- BLOCK_SIZE, 64, block width in bits (4 words)
- READ_LATENCY, 4, cycles m_readM is held before m_rdata is valid; must be >= 1
- WRITE_LATENCY, 1, cycles m_writeM is held; must be >= 1

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  instruction block read request; held high until i_done
- i_address  in  WORD_SIZE  instruction address; low 2 bits ignored
- i_done  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  BLOCK_SIZE  fetched block
- d_req  in  1  data request; held high until d_done
- d_we  in  1  1 = block write, 0 = block read; stable while d_req is high
- d_address  in  WORD_SIZE  data address; low 2 bits ignored
- d_wdata  in  BLOCK_SIZE  block to write
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  BLOCK_SIZE  read block, valid with d_done for reads
- m_readM  out  1  memory read strobe
- m_writeM  out  1  memory write strobe
- m_address  out  WORD_SIZE  block-aligned address, {addr[WORD_SIZE-1:2], 2'b00}
- m_wdata  out  BLOCK_SIZE  write block
- m_rdata  in  BLOCK_SIZE  memory read data
- busy  out  1  high in any non-IDLE state

## Operation
- States: IDLE, I_READ, D_READ, D_WRITE.
- Arbitration happens in IDLE only, with round-robin on simultaneous requests.
  - The requester not granted last wins a tie.
  - The last-grant flag resets to "I", so D wins the first tie.
  - A single pending requester always wins.
- On grant:
  - Latch the address, and d_wdata for D_WRITE.
  - Load the countdown counter with READ_LATENCY-1 or WRITE_LATENCY-1.
  - Update last-grant.
- In I_READ and D_READ, m_readM = 1. In D_WRITE, m_writeM = 1 and m_wdata = the latched block.
- m_address holds the latched aligned address for every busy cycle. It is 0 in IDLE.
- The counter decrements each busy cycle. When it is 0:
  - Read states: m_rdata is registered into i_rdata or d_rdata.
  - The matching done output is registered high.
  - The state returns to IDLE.
- A done pulse lasts exactly one cycle (the first IDLE cycle).
  - During that cycle the arbiter masks the just-completed requester's req, because the requester is still deasserting.
  - The other requester may be granted at the end of that cycle.
- i_rdata and d_rdata hold their value until the next completed read of the same port.
- The counter width is clog2(max(READ_LATENCY, WRITE_LATENCY)). It never wraps: a count of 0 always exits the busy state.
- A request arriving while busy waits; no request is dropped.
- Reset (asynchronous, any time, including mid-transfer):
  - State goes to IDLE, all outputs go to 0, last-grant goes to "I".
  - The in-flight transfer is abandoned and no done is issued.

## Timing
- Reset values: i_done = d_done = 0, i_rdata = d_rdata = 0, m_readM = m_writeM = 0, m_address = 0, m_wdata = 0, busy = 0.
- Read, with req first seen in IDLE at cycle 0:
  - m_readM is high in cycles 1..READ_LATENCY.
  - m_rdata is sampled at the end of cycle READ_LATENCY.
  - done is high in cycle READ_LATENCY+1 (cycle 5 by default).
- Write, same reference point:
  - m_writeM is high in cycles 1..WRITE_LATENCY.
  - done is high in cycle WRITE_LATENCY+1 (cycle 2 by default).
- The earliest next grant is at the end of the done cycle. Back-to-back transfers therefore have a one-cycle gap with no strobe.
- m_readM and m_writeM are never high in the same cycle.

## Test plan
- **Single I read:**
  - Stimulus: i_req=1, i_address=16'h0025, memory model returns 64'h6000_f01c_6100_f41c.
  - Required: m_address=16'h0024 and m_readM high in cycles 1–4; i_done in cycle 5 with i_rdata=64'h6000_f01c_6100_f41c; busy low in cycle 5.
- **Single D write:**
  - Stimulus: d_req=1, d_we=1, d_address=16'h001d, d_wdata=64'h1111_2222_3333_4444.
  - Required: m_writeM high in cycle 1 only, with m_address=16'h001c and m_wdata equal to d_wdata; d_done in cycle 2.
- **Simultaneous requests after reset:**
  - Stimulus: i_req and d_req (read) both high at cycle 0.
  - Required: D is served first, with d_done in cycle 5; the I grant follows at the end of cycle 5; i_done in cycle 10.
- **Fairness:**
  - Stimulus: d_req is re-asserted continuously while i_req stays pending.
  - Required: grants alternate D, I, D, I; neither requester is ever granted twice in a row while the other waits.
- **Reset mid-read:**
  - Stimulus: reset_n pulled low in cycle 2 of an I read.
  - Required: m_readM, busy and m_address are 0 immediately (asynchronously); no i_done ever appears; after release a new d_req completes normally in 5 cycles.
- **Parameter sweep:**
  - Stimulus: READ_LATENCY=1, WRITE_LATENCY=3.
  - Required: a read gives done in cycle 2; a write holds m_writeM for cycles 1–3 and gives done in cycle 4.
